// File: rtl/steak_drawer_if.sv
// Bus between the steak colour source and the sprite rasteriser / VGA writer.
interface steak_drawer_if;
  // plot is a valid-only strobe with no ready: the adapter must take every
  // pixel presented while plot is high; x, y and colour qualify that pixel.
  logic       go;
  logic [8:0] steakMuscle;
  logic [8:0] steakFat;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [1:0] state;

  modport master (
    output go, steakMuscle, steakFat,
    input  x, y, colour, plot, busy, done, state
  );

  modport slave (
    input  go, steakMuscle, steakFat,
    output x, y, colour, plot, busy, done, state
  );
endinterface

// File: rtl/steak_drawer.sv
// Rasterises a rectangular steak sprite (fat border, muscle interior) into the
// VGA framebuffer one pixel per clock, redrawing whenever the colours change.
module steak_drawer #(
  parameter logic [7:0] X_ORIGIN = 8'd72,
  parameter logic [6:0] Y_ORIGIN = 7'd56,
  parameter int         WIDTH    = 16,
  parameter int         HEIGHT   = 8,
  parameter int         BORDER   = 2
) (
  input  logic          clock,
  input  logic          reset,
  steak_drawer_if.slave bus
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(WIDTH - BORDER);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(HEIGHT - BORDER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [8:0]    lat_muscle, lat_fat;
  logic [8:0]    last_muscle, last_fat;
  logic          pending;
  logic          trigger;
  logic          last_pixel;
  logic          border;

  assign trigger = (state_q == IDLE) &&
                   (bus.go || pending ||
                    (bus.steakMuscle != last_muscle) ||
                    (bus.steakFat != last_fat));

  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = DRAW;
      DRAW:    if (last_pixel) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pending comes out of reset set so the first sweep overwrites whatever
  // partial sprite an interrupted sweep may have left behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      lat_muscle  <= '0;
      lat_fat     <= '0;
      last_muscle <= '0;
      last_fat    <= '0;
      pending     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            lat_muscle  <= bus.steakMuscle;
            lat_fat     <= bus.steakFat;
            last_muscle <= bus.steakMuscle;
            last_fat    <= bus.steakFat;
            pending     <= 1'b0;
            col         <= '0;
            row         <= '0;
          end
        end
        DRAW: begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if ((bus.steakMuscle != lat_muscle) || (bus.steakFat != lat_fat))
            pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: nothing here depends on the live input colours or go.
  always_comb begin
    border     = (col < COL_LO) || (col >= COL_HI) ||
                 (row < ROW_LO) || (row >= ROW_HI);
    bus.plot   = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.x      = X_ORIGIN;
    bus.y      = Y_ORIGIN;
    bus.colour = '0;
    bus.state  = state_q;
    case (state_q)
      DRAW: begin
        bus.plot   = 1'b1;
        bus.busy   = 1'b1;
        bus.x      = X_ORIGIN + 8'(col);
        bus.y      = Y_ORIGIN + 7'(row);
        bus.colour = border ? lat_fat : lat_muscle;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_steak_drawer.sv
// Scoreboard bench for steak_drawer: directed sweeps, colour changes mid-sweep,
// held/pulsed go, and asynchronous reset in the middle of a sweep.
module tb_steak_drawer;

  logic clk;
  logic rst;

  steak_drawer_if bus ();

  steak_drawer dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [23:0] exp_q[$];
  int tests    = 0;
  int fails    = 0;
  int done_seen = 0;
  int exp_done  = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected sprite: 16x8 at (72,56), fat where col<2, col>=14, row<2, row>=6.
  task automatic push_sweep(input logic [8:0] m, input logic [8:0] f);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        logic       edge_px;
        logic [7:0] ex;
        logic [6:0] ey;
        edge_px = (c < 2) || (c >= 14) || (r < 2) || (r >= 6);
        ex = 8'(72 + c);
        ey = 7'(56 + r);
        exp_q.push_back({ex, ey, edge_px ? f : m});
      end
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (bus.plot) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%o expected no pixel",
                 bus.x, bus.y, bus.colour);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({bus.x, bus.y, bus.colour} !== e) begin
          fails++;
          $display("FAIL pixel: got x=%0d y=%0d colour=%o expected x=%0d y=%0d colour=%o",
                   bus.x, bus.y, bus.colour, e[23:16], e[15:9], e[8:0]);
        end
      end
      tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL draw_flags: got busy=%b done=%b expected busy=1 done=0",
                 bus.busy, bus.done);
      end
    end else begin
      tests++;
      if (bus.x !== 8'd72 || bus.y !== 7'd56 || bus.colour !== 9'd0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: got x=%0d y=%0d colour=%o busy=%b expected 72 56 0 0",
                 bus.x, bus.y, bus.colour, bus.busy);
      end
    end
    if (bus.done) done_seen++;
  end

  // driver tasks
  task automatic wait_plots(input int n);
    int cnt = 0;
    int guard = 0;
    while (cnt < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (bus.plot) cnt++;
    end
    check("wait_plots_count", cnt, n);
  endtask

  task automatic measure_gap(output int g);
    int guard = 0;
    g = 0;
    forever begin
      @(negedge clk);
      if (bus.plot || guard >= 500) break;
      g++;
      guard++;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, exp_done);
  endtask

  // stimulus
  initial begin
    int cnt;
    int gap;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.steakMuscle = 9'd0;
    bus.steakFat = 9'd0;

    // reset state
    #1;
    check("rst_plot",   int'(bus.plot),   0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_done",   int'(bus.done),   0);
    check("rst_x",      int'(bus.x),      72);
    check("rst_y",      int'(bus.y),      56);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_state",  int'(bus.state),  0);

    // release with zero inputs: one all-black sweep
    push_sweep(9'd0, 9'd0);
    exp_done++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle(150);

    // colour change from idle, with done latency
    @(negedge clk);
    bus.steakMuscle = 9'o700;
    bus.steakFat    = 9'o777;
    push_sweep(9'o700, 9'o777);
    exp_done++;
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done) break;
    end
    check("done_latency", cnt, 129);
    settle(10);

    // colour change at pixel 40 of a sweep
    @(negedge clk);
    bus.steakMuscle = 9'o070;
    bus.steakFat    = 9'o007;
    push_sweep(9'o070, 9'o007);
    wait_plots(40);
    bus.steakMuscle = 9'o005;
    bus.steakFat    = 9'o500;
    push_sweep(9'o005, 9'o500);
    exp_done += 2;
    settle(300);

    // go held high: back-to-back sweeps with 2-cycle gaps
    @(negedge clk);
    bus.go = 1'b1;
    push_sweep(9'o005, 9'o500);
    push_sweep(9'o005, 9'o500);
    push_sweep(9'o005, 9'o500);
    exp_done += 3;
    wait_plots(128);
    measure_gap(gap);
    check("go_gap_1", gap, 2);
    wait_plots(127);
    measure_gap(gap);
    check("go_gap_2", gap, 2);
    bus.go = 1'b0;
    settle(150);

    // reset asserted at pixel 60, released 3 cycles later
    @(negedge clk);
    bus.go = 1'b1;
    push_sweep(9'o005, 9'o500);
    wait_plots(1);
    bus.go = 1'b0;
    wait_plots(59);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_plot",   int'(bus.plot),   0);
    check("async_rst_busy",   int'(bus.busy),   0);
    check("async_rst_x",      int'(bus.x),      72);
    check("async_rst_y",      int'(bus.y),      56);
    check("async_rst_colour", int'(bus.colour), 0);
    check("async_rst_state",  int'(bus.state),  0);
    exp_q.delete();
    push_sweep(9'o005, 9'o500);
    exp_done++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle(150);

    // go pulsed during DRAW with unchanged colours: no extra sweep
    @(negedge clk);
    bus.go = 1'b1;
    push_sweep(9'o005, 9'o500);
    exp_done++;
    wait_plots(1);
    bus.go = 1'b0;
    wait_plots(49);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    settle(200);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
